// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: exec codes, FSM encoding and
// small decode helpers used by the stage and its load-extension unit.
package mem_stage_pkg;

   // Exec codes seen by the MEM stage. Anything not listed as a memory op
   // (including EXEC_ADD and unknown codes) is passed straight through.
   localparam logic [4:0] EXEC_ADD = 5'h00;
   localparam logic [4:0] EXEC_LB  = 5'h10;
   localparam logic [4:0] EXEC_LH  = 5'h11;
   localparam logic [4:0] EXEC_LW  = 5'h12;
   localparam logic [4:0] EXEC_LBU = 5'h13;
   localparam logic [4:0] EXEC_LHU = 5'h14;
   localparam logic [4:0] EXEC_SB  = 5'h15;
   localparam logic [4:0] EXEC_SH  = 5'h16;
   localparam logic [4:0] EXEC_SW  = 5'h17;

   localparam logic [31:0] ZERO32 = 32'h0000_0000;
   localparam logic [4:0]  ZERO5  = 5'h00;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } mem_state_e;

   // Number of bytes moved by an exec code; 0 marks a non-memory op.
   function automatic logic [2:0] exec_nbytes(input logic [4:0] exec);
      case (exec)
         EXEC_LB, EXEC_LBU, EXEC_SB: exec_nbytes = 3'd1;
         EXEC_LH, EXEC_LHU, EXEC_SH: exec_nbytes = 3'd2;
         EXEC_LW, EXEC_SW:           exec_nbytes = 3'd4;
         default:                    exec_nbytes = 3'd0;
      endcase
   endfunction

   function automatic logic is_mem_op(input logic [4:0] exec);
      is_mem_op = (exec_nbytes(exec) != 3'd0);
   endfunction

   function automatic logic is_store_op(input logic [4:0] exec);
      is_store_op = (exec == EXEC_SB) || (exec == EXEC_SH) || (exec == EXEC_SW);
   endfunction

   // Halfword ops need addr[0]==0, word ops need addr[1:0]==0.
   function automatic logic is_misaligned(input logic [4:0] exec, input logic [1:0] addr_lo);
      case (exec_nbytes(exec))
         3'd2:    is_misaligned = addr_lo[0];
         3'd4:    is_misaligned = (addr_lo != 2'b00);
         default: is_misaligned = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// Load-result formatter: takes the little-endian byte buffer assembled by
// the MEM stage and sign- or zero-extends it according to the load type.
module mem_stage_load_extend
   import mem_stage_pkg::*;
#(
   parameter int XLEN = 32
)(
   input  logic [4:0]      exec_i,
   input  logic [XLEN-1:0] bytes_i,
   output logic [XLEN-1:0] result_o
);

   // Select width and extension mode; LW (and any other code) uses all bytes
   always_comb begin
      case (exec_i)
         EXEC_LB:  result_o = {{(XLEN-8){bytes_i[7]}}, bytes_i[7:0]};
         EXEC_LBU: result_o = {{(XLEN-8){1'b0}}, bytes_i[7:0]};
         EXEC_LH:  result_o = {{(XLEN-16){bytes_i[15]}}, bytes_i[15:0]};
         EXEC_LHU: result_o = {{(XLEN-16){1'b0}}, bytes_i[15:0]};
         default:  result_o = bytes_i;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage core. Non-memory ops pass through with zero
// latency; loads/stores are performed one byte at a time over the 8-bit
// memory-controller port while mem_stall_req freezes the upstream stages.
// Optional build macro: MEM_MISALIGN_TRAP_EN (adds misalign_out and skips
// misaligned halfword/word accesses instead of executing them).
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int EXEC_W = 5
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [5:0]        stall,
   input  logic [XLEN-1:0]   exmem_alu_in,
   input  logic [XLEN-1:0]   exmem_rs2_in,
   input  logic [EXEC_W-1:0] exmem_exec_in,
   input  logic [4:0]        exmem_rdest_in,
   input  logic              exmem_we_in,
   output logic              mem_req,
   output logic              mem_we,
   output logic [XLEN-1:0]   mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [7:0]        mem_rdata,
   output logic              mem_stall_req,
   output logic [XLEN-1:0]   mem_wdata_out,
   output logic [4:0]        mem_rdest_out,
   output logic              mem_we_out
`ifdef MEM_MISALIGN_TRAP_EN
   ,
   output logic              misalign_out
`endif
);

   mem_state_e        state_q, state_d;
   logic [1:0]        k_q;
   logic [XLEN-1:0]   rdbuf_q;
   logic [XLEN-1:0]   addr_q;
   logic [XLEN-1:0]   data_q;
   logic [EXEC_W-1:0] exec_q;
   logic [4:0]        rdest_q;
   logic              we_q;
   logic              misal_q;

   logic              misal_now;
   logic              last_byte;
   logic              store_q;
   logic [XLEN-1:0]   load_result;
   logic              stall_unused;

   // Only the MEM/WB hold bit matters to this stage
   assign stall_unused = ^{stall[5], stall[3:0]};

`ifdef MEM_MISALIGN_TRAP_EN
   assign misal_now = is_misaligned(exmem_exec_in, exmem_alu_in[1:0]);
   assign misalign_out = (state_q == ST_DONE) && misal_q;
`else
   assign misal_now = 1'b0;
`endif

   // The byte in flight is the final one when k reaches N-1
   assign last_byte = ({1'b0, k_q} == (exec_nbytes(exec_q) - 3'd1));
   assign store_q   = is_store_op(exec_q);

   mem_stage_load_extend #(
      .XLEN(XLEN)
   ) u_load_extend (
      .exec_i  (exec_q),
      .bytes_i (rdbuf_q),
      .result_o(load_result)
   );

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (is_mem_op(exmem_exec_in)) begin
               state_d = misal_now ? ST_DONE : ST_REQ;
            end
         end
         ST_REQ: begin
            if (mem_gnt) begin
               if (store_q) begin
                  state_d = last_byte ? ST_DONE : ST_REQ;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (mem_rvalid) begin
               state_d = last_byte ? ST_DONE : ST_REQ;
            end
         end
         ST_DONE: begin
            if (!stall[4]) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Access context, byte counter and read buffer; the op is latched on entry
   // so the result stays stable in DONE even if EX/MEM moves on
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k_q     <= 2'd0;
         rdbuf_q <= ZERO32;
         addr_q  <= ZERO32;
         data_q  <= ZERO32;
         exec_q  <= ZERO5;
         rdest_q <= ZERO5;
         we_q    <= 1'b0;
         misal_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (is_mem_op(exmem_exec_in)) begin
                  k_q     <= 2'd0;
                  rdbuf_q <= ZERO32;
                  addr_q  <= exmem_alu_in;
                  data_q  <= exmem_rs2_in;
                  exec_q  <= exmem_exec_in;
                  rdest_q <= exmem_rdest_in;
                  we_q    <= exmem_we_in;
                  misal_q <= misal_now;
               end
            end
            ST_REQ: begin
               if (mem_gnt && store_q) begin
                  k_q <= k_q + 2'd1;
               end
            end
            ST_WAIT: begin
               if (mem_rvalid) begin
                  rdbuf_q[{k_q, 3'b000} +: 8] <= mem_rdata;
                  k_q <= k_q + 2'd1;
               end
            end
            ST_DONE: begin
               if (!stall[4]) begin
                  k_q     <= 2'd0;
                  misal_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // FSM outputs: memory port, stall request and MEM/WB result
   always_comb begin
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      mem_addr      = ZERO32;
      mem_wdata     = 8'h00;
      mem_stall_req = 1'b0;
      mem_wdata_out = ZERO32;
      mem_rdest_out = ZERO5;
      mem_we_out    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (is_mem_op(exmem_exec_in)) begin
               mem_stall_req = 1'b1;
            end else begin
               mem_wdata_out = exmem_alu_in;
               mem_rdest_out = exmem_rdest_in;
               mem_we_out    = exmem_we_in;
            end
         end
         ST_REQ: begin
            mem_stall_req = 1'b1;
            mem_req       = 1'b1;
            mem_we        = store_q;
            mem_addr      = addr_q + XLEN'(k_q);
            mem_wdata     = store_q ? data_q[{k_q, 3'b000} +: 8] : 8'h00;
         end
         ST_WAIT: begin
            mem_stall_req = 1'b1;
         end
         ST_DONE: begin
            mem_rdest_out = rdest_q;
            if (misal_q) begin
               mem_wdata_out = addr_q;
            end else if (!store_q) begin
               mem_wdata_out = load_result;
               mem_we_out    = we_q;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a byte-wide memory-controller model with
// programmable grant and read-return delays answers the DUT; expected store
// bytes, load addresses and stage results are queued when an op is driven.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic [31:0] exmem_alu_in, exmem_rs2_in;
   logic [4:0]  exmem_exec_in, exmem_rdest_in;
   logic        exmem_we_in;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_gnt, mem_rvalid;
   logic [7:0]  mem_rdata;
   logic        mem_stall_req;
   logic [31:0] mem_wdata_out;
   logic [4:0]  mem_rdest_out;
   logic        mem_we_out;
`ifdef MEM_MISALIGN_TRAP_EN
   logic        misalign_out;
`endif

   mem_stage dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .exmem_alu_in  (exmem_alu_in),
      .exmem_rs2_in  (exmem_rs2_in),
      .exmem_exec_in (exmem_exec_in),
      .exmem_rdest_in(exmem_rdest_in),
      .exmem_we_in   (exmem_we_in),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_gnt       (mem_gnt),
      .mem_rvalid    (mem_rvalid),
      .mem_rdata     (mem_rdata),
      .mem_stall_req (mem_stall_req),
      .mem_wdata_out (mem_wdata_out),
      .mem_rdest_out (mem_rdest_out),
      .mem_we_out    (mem_we_out)
`ifdef MEM_MISALIGN_TRAP_EN
      ,
      .misalign_out  (misalign_out)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] wdata;
      logic [4:0]  rdest;
      logic        we;
      logic        mis;
   } res_t;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0]  mem_model [logic [31:0]];
   res_t        exp_q[$];
   logic [39:0] wr_q[$];
   logic [31:0] rd_addr_q[$];

   // Memory-controller model state
   int          gnt_delay, rv_delay, req_cnt, rd_cnt, reads_done, req_cycles;
   bit          rd_pend, saw_req;
   logic [31:0] rd_addr;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One controller cycle, evaluated at a negedge; drives gnt/rvalid for the next posedge
   task automatic tick();
      bit pend_before;
      pend_before = rd_pend;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 8'h00;
      if (rd_pend) begin
         rd_cnt--;
         if (rd_cnt <= 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_model.exists(rd_addr) ? mem_model[rd_addr] : 8'h00;
            rd_pend    = 1'b0;
            reads_done++;
         end
      end
      if (mem_req) begin
         saw_req = 1'b1;
         req_cycles++;
         chk("one_outstanding", 64'(pend_before), 64'(0));
         if (req_cnt >= gnt_delay) begin
            mem_gnt = 1'b1;
            req_cnt = 0;
            if (mem_we) begin
               if (wr_q.size() == 0) begin
                  chk("store_unexpected", {mem_addr, mem_wdata}, 64'(0));
               end else begin
                  chk("store_byte", {mem_addr, mem_wdata}, wr_q.pop_front());
               end
               mem_model[mem_addr] = mem_wdata;
            end else begin
               if (rd_addr_q.size() == 0) begin
                  chk("load_unexpected", mem_addr, 64'(0));
               end else begin
                  chk("load_addr", mem_addr, rd_addr_q.pop_front());
               end
               rd_pend = 1'b1;
               rd_cnt  = rv_delay;
               rd_addr = mem_addr;
            end
         end else begin
            req_cnt++;
         end
      end
   endtask

   // Wait for DONE, compare the result, hold DONE for 'hold' cycles, then release
   task automatic finish_op(input int hold, input bit exp_req);
      res_t e;
      bit   done;
      done = 1'b0;
      for (int b = 0; b < 200; b++) begin
         @(negedge clk);
         tick();
         if (!mem_stall_req) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) chk("done_timeout", 64'(0), 64'(1));
      e = exp_q.pop_front();
      chk("res_wdata", mem_wdata_out, e.wdata);
      chk("res_we", mem_we_out, e.we);
      chk("res_rdest", mem_rdest_out, e.rdest);
`ifdef MEM_MISALIGN_TRAP_EN
      chk("res_misalign", misalign_out, e.mis);
`endif
      chk("req_seen", 64'(saw_req), 64'(exp_req));
      $display("op exec=%02h addr=%08h -> wdata_out=%08h we=%0b rdest=%0d", exmem_exec_in,
               exmem_alu_in, mem_wdata_out, mem_we_out, mem_rdest_out);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         tick();
         chk("hold_stall_req", mem_stall_req, 64'(0));
         chk("hold_wdata", mem_wdata_out, e.wdata);
         chk("hold_we", mem_we_out, e.we);
      end
      stall[4]       = 1'b0;
      exmem_exec_in  = EXEC_ADD;
      exmem_alu_in   = 32'h0BAD_F00D;
      exmem_we_in    = 1'b1;
      exmem_rdest_in = 5'd9;
      @(negedge clk);
      tick();
      chk("exit_idle_wdata", mem_wdata_out, 64'h0BAD_F00D);
      chk("exit_idle_stall", mem_stall_req, 64'(0));
      chk("wr_q_drained", 64'(wr_q.size()), 64'(0));
      chk("rd_q_drained", 64'(rd_addr_q.size()), 64'(0));
   endtask

   // Drive one op (at a negedge) and run it to completion
   task automatic run_op(input logic [4:0] ex, input logic [31:0] alu, input logic [31:0] rs2,
                         input logic [4:0] rd, input logic we, input int gd, input int rvd,
                         input int hold, input res_t exp_res, input bit is_mem, input bit exp_req);
      res_t e;
      exmem_exec_in  = ex;
      exmem_alu_in   = alu;
      exmem_rs2_in   = rs2;
      exmem_rdest_in = rd;
      exmem_we_in    = we;
      gnt_delay  = gd;
      rv_delay   = rvd;
      req_cnt    = 0;
      reads_done = 0;
      req_cycles = 0;
      saw_req    = 1'b0;
      stall[4]   = (hold > 0);
      exp_q.push_back(exp_res);
      #1;
      if (!is_mem) begin
         e = exp_q.pop_front();
         chk("pt_wdata", mem_wdata_out, e.wdata);
         chk("pt_we", mem_we_out, e.we);
         chk("pt_rdest", mem_rdest_out, e.rdest);
         chk("pt_stall_req", mem_stall_req, 64'(0));
         chk("pt_mem_req", mem_req, 64'(0));
         @(negedge clk);
         tick();
         chk("pt_mem_req_next", 64'(saw_req), 64'(0));
         chk("pt_wdata_next", mem_wdata_out, e.wdata);
         $display("op exec=%02h alu=%08h -> pass-through wdata_out=%08h", ex, alu, mem_wdata_out);
      end else begin
         chk("idle_stall_req", mem_stall_req, 64'(1));
         chk("idle_inert_we", mem_we_out, 64'(0));
         finish_op(hold, exp_req);
      end
   endtask

   initial begin
      bit hit;
      rst = 1'b1;
      stall = 6'b0;
      exmem_alu_in = 32'h0;
      exmem_rs2_in = 32'h0;
      exmem_exec_in = EXEC_ADD;
      exmem_rdest_in = 5'd0;
      exmem_we_in = 1'b0;
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata = 8'h00;
      rd_pend = 1'b0;
      saw_req = 1'b0;
      mem_model[32'h20] = 8'h80;
      mem_model[32'h41] = 8'hFE;
      mem_model[32'h42] = 8'h7F;
      for (int i = 0; i < 4; i++) mem_model[32'h200 + i] = 8'(8'h11 * (i + 1));

      // Reset state, with a load sitting on the inputs
      exmem_exec_in = EXEC_LW;
      exmem_alu_in  = 32'h200;
      repeat (2) @(negedge clk);
      chk("rst_mem_req", mem_req, 64'(0));
      chk("rst_wdata_out", mem_wdata_out, 64'(0));
      exmem_exec_in = EXEC_ADD;
      exmem_alu_in  = 32'h55;
      exmem_we_in   = 1'b1;
      exmem_rdest_in = 5'd4;
      #1;
      chk("rst_passthrough", mem_wdata_out, 64'h55);
      @(negedge clk);
      rst = 1'b0;

      // ADD pass-through and an unknown exec code
      run_op(EXEC_ADD, 32'h1234, 32'h0, 5'd3, 1'b1, 0, 1, 0, '{32'h1234, 5'd3, 1'b1, 1'b0}, 1'b0, 1'b0);
      run_op(5'h1F, 32'hCAFE_0001, 32'h0, 5'd7, 1'b0, 0, 1, 0, '{32'hCAFE_0001, 5'd7, 1'b0, 1'b0}, 1'b0, 1'b0);

      // SW, grant every cycle: four bytes, little-endian
      wr_q.push_back({32'h100, 8'hD4});
      wr_q.push_back({32'h101, 8'hC3});
      wr_q.push_back({32'h102, 8'hB2});
      wr_q.push_back({32'h103, 8'hA1});
      run_op(EXEC_SW, 32'h100, 32'hA1B2_C3D4, 5'd5, 1'b1, 0, 1, 0, '{32'h0, 5'd5, 1'b0, 1'b0}, 1'b1, 1'b1);
      chk("sw_req_cycles", 64'(req_cycles), 64'(4));

      // LB / LBU with read data three cycles after grant
      rd_addr_q.push_back(32'h20);
      run_op(EXEC_LB, 32'h20, 32'h0, 5'd10, 1'b1, 0, 3, 0, '{32'hFFFF_FF80, 5'd10, 1'b1, 1'b0}, 1'b1, 1'b1);
      rd_addr_q.push_back(32'h20);
      run_op(EXEC_LBU, 32'h20, 32'h0, 5'd11, 1'b1, 0, 3, 0, '{32'h0000_0080, 5'd11, 1'b1, 1'b0}, 1'b1, 1'b1);

      // LH at an odd address, grant delayed two cycles per byte
`ifdef MEM_MISALIGN_TRAP_EN
      run_op(EXEC_LH, 32'h41, 32'h0, 5'd12, 1'b1, 2, 1, 0, '{32'h41, 5'd12, 1'b0, 1'b1}, 1'b1, 1'b0);
`else
      rd_addr_q.push_back(32'h41);
      rd_addr_q.push_back(32'h42);
      run_op(EXEC_LH, 32'h41, 32'h0, 5'd12, 1'b1, 2, 1, 0, '{32'h0000_7FFE, 5'd12, 1'b1, 1'b0}, 1'b1, 1'b1);
`endif

      // LW reading back the SW data while MEM/WB is held for three cycles
      for (int i = 0; i < 4; i++) rd_addr_q.push_back(32'h100 + i);
      run_op(EXEC_LW, 32'h100, 32'h0, 5'd13, 1'b1, 1, 1, 3, '{32'hA1B2_C3D4, 5'd13, 1'b1, 1'b0}, 1'b1, 1'b1);

      // SH then LH/LHU of the same halfword, SB then LBU
      wr_q.push_back({32'h102, 8'hEF});
      wr_q.push_back({32'h103, 8'hBE});
      run_op(EXEC_SH, 32'h102, 32'h1234_BEEF, 5'd14, 1'b1, 1, 1, 0, '{32'h0, 5'd14, 1'b0, 1'b0}, 1'b1, 1'b1);
      rd_addr_q.push_back(32'h102);
      rd_addr_q.push_back(32'h103);
      run_op(EXEC_LH, 32'h102, 32'h0, 5'd15, 1'b1, 0, 2, 0, '{32'hFFFF_BEEF, 5'd15, 1'b1, 1'b0}, 1'b1, 1'b1);
      rd_addr_q.push_back(32'h102);
      rd_addr_q.push_back(32'h103);
      run_op(EXEC_LHU, 32'h102, 32'h0, 5'd16, 1'b1, 0, 1, 0, '{32'h0000_BEEF, 5'd16, 1'b1, 1'b0}, 1'b1, 1'b1);
      wr_q.push_back({32'h105, 8'h5A});
      run_op(EXEC_SB, 32'h105, 32'hFFFF_FF5A, 5'd17, 1'b1, 0, 1, 0, '{32'h0, 5'd17, 1'b0, 1'b0}, 1'b1, 1'b1);
      rd_addr_q.push_back(32'h105);
      run_op(EXEC_LBU, 32'h105, 32'h0, 5'd18, 1'b1, 0, 1, 0, '{32'h0000_005A, 5'd18, 1'b1, 1'b0}, 1'b1, 1'b1);

      // Reset while waiting for the second byte of an LW, then restart
      exmem_exec_in  = EXEC_LW;
      exmem_alu_in   = 32'h200;
      exmem_rdest_in = 5'd19;
      exmem_we_in    = 1'b1;
      gnt_delay = 0;
      rv_delay  = 3;
      req_cnt = 0;
      reads_done = 0;
      saw_req = 1'b0;
      rd_addr_q.push_back(32'h200);
      rd_addr_q.push_back(32'h201);
      hit = 1'b0;
      for (int b = 0; b < 100; b++) begin
         @(negedge clk);
         tick();
         if (reads_done >= 1 && rd_pend) begin
            hit = 1'b1;
            break;
         end
      end
      chk("rst_reach_wait", 64'(hit), 64'(1));
      @(posedge clk);
      #2;
      mem_gnt = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst_mem_req", mem_req, 64'(0));
      chk("midrst_idle_stall", mem_stall_req, 64'(1));
      chk("midrst_wdata_out", mem_wdata_out, 64'(0));
      @(negedge clk);
      rd_pend = 1'b0;
      mem_rvalid = 1'b0;
      rst = 1'b0;
      req_cnt = 0;
      saw_req = 1'b0;
      for (int i = 0; i < 4; i++) rd_addr_q.push_back(32'h200 + i);
      exp_q.push_back('{32'h4433_2211, 5'd19, 1'b1, 1'b0});
      finish_op(0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Global watchdog so the bench always terminates
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation time limit reached");
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RISC-V core.
- Sits between the EX/MEM pipeline register and the MEM/WB register.
- Consumes the latched ALU result, rs2 data, exec code, destination register and write-enable.
- Performs loads and stores byte-serially over the 8-bit memory-controller port, and holds the pipeline via a stall request until the access completes.

Parameters:
- XLEN, 32, datapath width.
- EXEC_W, 5, width of the exec-code field.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous reset, active-high.
- stall  in  6  pipeline stall vector. Bit 4 set means MEM/WB is held.
- exmem_alu_in  in  32  ALU result. Used as the effective address for memory ops.
- exmem_rs2_in  in  32  store data.
- exmem_exec_in  in  5  exec code.
- exmem_rdest_in  in  5  destination register.
- exmem_we_in  in  1  register write-enable.
- mem_req  out  1  byte request to the memory controller.
- mem_we  out  1  1 = write byte, 0 = read byte.
- mem_addr  out  32  byte address.
- mem_wdata  out  8  write byte.
- mem_gnt  in  1  controller accepted the request this cycle.
- mem_rvalid  in  1  read byte returned.
- mem_rdata  in  8  returned read byte.
- mem_stall_req  out  1  request that the stall controller freeze IF..EX/MEM.
- mem_wdata_out  out  32  result to MEM/WB.
- mem_rdest_out  out  5  destination register to MEM/WB.
- mem_we_out  out  1  write-enable to MEM/WB.

Behaviour:
- Non-memory exec codes: combinational pass-through, zero latency.
  - mem_wdata_out = exmem_alu_in; rdest and we passed unchanged.
  - mem_stall_req = 0, mem_req = 0.
- Memory ops: LB, LH, LW, LBU, LHU, SB, SH, SW. Byte count N = 1, 2 or 4.
  - Byte k uses address alu_in + k, k = 0..N-1.
  - Little-endian: store byte k = rs2[8k+7:8k]; load byte k lands at result[8k+7:8k].
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: memory op present → load byte counter = 0, go to REQ. mem_stall_req = 1.
  - REQ: mem_req = 1, with mem_addr/mem_we/mem_wdata for byte k.
    - Requests hold stable until mem_gnt.
    - On gnt for a store: k++. Last byte → DONE, else stay in REQ.
    - On gnt for a load: go to WAIT.
  - WAIT: mem_req = 0. On mem_rvalid, capture the byte into the buffer and k++. Last byte → DONE, else → REQ.
    - rvalid in any other state is ignored.
  - DONE: mem_stall_req = 0. Output registered result: zero/sign-extended load data for loads; for stores, we_out = 0 and wdata_out = 0.
    - Exit to IDLE when stall[4] = 0; hold DONE while stall[4] = 1.
- mem_stall_req = 1 in REQ and WAIT, and in IDLE when a memory op is present. 0 otherwise.
- Sign extension: LB from bit 7, LH from bit 15. LBU/LHU zero-fill.
- At most one outstanding read. No new request is issued before rvalid.
- Outputs from REQ/WAIT to MEM/WB are inert: we_out = 0, rdest_out = 0, wdata_out = 0.
- Reset (async, any state, including mid-access): FSM = IDLE, k = 0, data buffer = 0, mem_req = 0. Outputs then follow IDLE rules on the current inputs.
  - A store interrupted by reset leaves partial bytes written. This is accepted.
- Unknown exec code: treated as non-memory pass-through.

Optional Feature:
- MEM_MISALIGN_TRAP_EN
- Defined:
  - Adds output misalign_out (1 bit).
  - LH/LHU/SH with addr[0] ≠ 0, or LW/SW with addr[1:0] ≠ 0, issue no memory request.
  - The op goes straight to DONE with misalign_out = 1, we_out = 0, wdata_out = alu_in.
  - misalign_out = 0 otherwise and at reset.
- Undefined: no port. Misaligned accesses execute normally byte-serially.

Decomposition:
- Shared package/define file holds:
  - Exec-code constants: LB, LH, LW, LBU, LHU, SB, SH, SW.
  - FSM state encodings.
  - Byte-count function exec → N.
  - zero32/zero5 constants.
- One natural sub-module, load_extend: combinational byte-buffer + exec → sign/zero-extended 32-bit result.

Test Plan:
- ADD exec, alu_in = 0x1234 → same cycle wdata_out = 0x1234, we_out passed, stall_req = 0, mem_req never asserted.
- SW addr 0x100, rs2 = 0xA1B2C3D4, gnt every cycle → writes D4@0x100, C3@0x101, B2@0x102, A1@0x103 in 4 cycles; stall_req drops in DONE; we_out = 0.
- LB addr 0x20, rdata 0x80 with rvalid 3 cycles after gnt → wdata_out = 0xFFFFFF80. Same with LBU → 0x00000080.
- LH addr 0x41, gnt delayed 2 cycles per byte, rdata 0xFE then 0x7F → 0x00007FFE. With MEM_MISALIGN_TRAP_EN → no mem_req, misalign_out = 1.
- LW completes while stall[4] = 1 for 3 cycles → DONE held with a stable result, stall_req = 0; IDLE only after stall[4] = 0.
- Assert rst during WAIT of an LW (second byte) → mem_req = 0 and FSM IDLE immediately. After release with the same LW on the inputs, the access restarts at byte 0.
